// File: rtl/image_loader_pkg.sv
// Shared definitions for the image loader and the VGA image memory it feeds:
// loader FSM states, default frame geometry and the packed 24-bit pixel type.
package image_loader_pkg;

    localparam int DEFAULT_IMAGE_WIDTH  = 90;
    localparam int DEFAULT_IMAGE_HEIGHT = 90;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        LAST = 2'd2
    } load_state_t;

endpackage

// File: rtl/counter.sv
// Parameterised up-counter with synchronous clear; it saturates at MAX rather
// than wrapping, so the count never leaves 0..MAX.
module counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && count != MAX) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/image_loader.sv
// Packs an R,G,B byte stream into 24-bit pixels and writes them in raster
// order to the image memory, one write strobe per pixel.
module image_loader
    import image_loader_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
    parameter int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output pixel_t            wr_data,
    output logic              busy,
    output logic              frame_done,
    output load_state_t       dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    load_state_t       state, state_next;
    logic [1:0]        phase;
    logic [7:0]        r_byte, g_byte;
    logic [ADDR_W-1:0] pix_addr;
    logic              accept, pixel_done, frame_start;

    assign in_ready    = (state == RECV);
    assign busy        = (state != IDLE);
    assign dbg_state   = state;
    assign accept      = in_valid && in_ready;
    assign frame_start = (state == IDLE) && start && !abort;
    // A B byte arriving together with abort belongs to a discarded frame.
    assign pixel_done  = accept && (phase == 2'd2) && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (frame_start) state_next = RECV;
            RECV: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pixel_done && pix_addr == LAST_ADDR) begin
                    state_next = LAST;
                end
            end
            LAST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    counter #(
        .W   (ADDR_W),
        .MAX (LAST_ADDR)
    ) u_pixel_counter (
        .clk   (clk),
        .reset (reset),
        .clear (frame_start),
        .en    (pixel_done),
        .count (pix_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= 2'd0;
            r_byte     <= 8'd0;
            g_byte     <= 8'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= pixel_done;
            frame_done <= pixel_done && (pix_addr == LAST_ADDR);
            if (frame_start || abort) begin
                phase <= 2'd0;
            end else if (accept) begin
                case (phase)
                    2'd0: begin
                        r_byte <= in_data;
                        phase  <= 2'd1;
                    end
                    2'd1: begin
                        g_byte <= in_data;
                        phase  <= 2'd2;
                    end
                    default: phase <= 2'd0;
                endcase
            end
            // Address and data only move with a write, so they hold otherwise.
            if (pixel_done) begin
                wr_addr <= pix_addr;
                wr_data <= {r_byte, g_byte, in_data};
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: a 5x5 instance for general and reset/abort behaviour
// and a 2x2 instance for a complete small frame.
module tb_image_loader;
    import image_loader_pkg::*;

    localparam int A_NPIX = 25;
    localparam int A_AW   = $clog2(A_NPIX);
    localparam int B_NPIX = 4;
    localparam int B_AW   = $clog2(B_NPIX);
    localparam int EXP_W  = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, abort_a, start_b, abort_b;
    logic [7:0]  in_data;
    logic        in_valid;

    logic            a_in_ready, a_wr_en, a_busy, a_frame_done;
    logic [A_AW-1:0] a_wr_addr;
    pixel_t          a_wr_data;
    load_state_t     a_dbg_state;
    logic            b_in_ready, b_wr_en, b_busy, b_frame_done;
    logic [B_AW-1:0] b_wr_addr;
    pixel_t          b_wr_data;
    load_state_t     b_dbg_state;

    image_loader #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .frame_done(a_frame_done), .dbg_state(a_dbg_state)
    );

    image_loader #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .frame_done(b_frame_done), .dbg_state(b_dbg_state)
    );

    // Scoreboard entries are {frame_done, addr[7:0], pixel[23:0]}.
    logic [EXP_W-1:0] exp_qa[$], exp_qb[$], obs_qa[$], obs_qb[$];
    logic [7:0]       frame_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    always @(negedge clk) begin
        if (a_wr_en || a_frame_done) obs_qa.push_back({a_frame_done, 8'(a_wr_addr), a_wr_data});
        if (b_wr_en || b_frame_done) obs_qb.push_back({b_frame_done, 8'(b_wr_addr), b_wr_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_abort(input bit sel);
        if (sel) abort_b = 1'b1; else abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        abort_b = 1'b0;
    endtask

    // Offers one byte until accepted; accepted bytes of a live frame feed the model.
    task automatic drive_byte(input bit sel, input logic [7:0] b, input bit with_abort);
        bit got;
        bit rdy;
        got      = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        if (with_abort) begin
            if (sel) abort_b = 1'b1; else abort_a = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            rdy = sel ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
        end
        in_valid = 1'b0;
        abort_a  = 1'b0;
        abort_b  = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        else if (!with_abort) frame_q.push_back(b);
    endtask

    // Reference model: every complete byte triple of the frame is one pixel,
    // written at its pixel index; the final pixel of the image flags frame_done.
    task automatic build_exp(input bit sel, input int npix);
        logic [EXP_W-1:0] e;
        for (int i = 0; i < frame_q.size() / 3; i++) begin
            e = {(i == npix - 1), 8'(i), frame_q[3*i], frame_q[3*i+1], frame_q[3*i+2]};
            if (sel) exp_qb.push_back(e); else exp_qa.push_back(e);
        end
        frame_q.delete();
    endtask

    task automatic compare_sb(input bit sel);
        int ne, no;
        logic [EXP_W-1:0] e, o;
        ne = sel ? exp_qb.size() : exp_qa.size();
        no = sel ? obs_qb.size() : obs_qa.size();
        chk($sformatf("write_count_dut%0d", sel), 64'(no), 64'(ne));
        for (int i = 0; i < ne && i < no; i++) begin
            e = sel ? exp_qb.pop_front() : exp_qa.pop_front();
            o = sel ? obs_qb.pop_front() : obs_qa.pop_front();
            chk($sformatf("write_dut%0d_%0d", sel, i), 64'(o), 64'(e));
        end
        exp_qa.delete(); obs_qa.delete();
        exp_qb.delete(); obs_qb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] last_px;
        reset    = 1'b1;
        start_a  = 1'b0; abort_a = 1'b0;
        start_b  = 1'b0; abort_b = 1'b0;
        in_data  = 8'd0;
        in_valid = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("reset_outputs", {a_wr_en, a_frame_done, a_busy, a_in_ready, a_wr_addr, a_wr_data}, 64'd0);
        chk("reset_state", a_dbg_state, IDLE);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;
        tick(2);
        chk("idle_after_release", {a_busy, a_in_ready}, 64'd0);

        // Full frame with random bytes and random stalls.
        pulse_start(1'b0);
        chk("busy_after_start", {a_busy, a_in_ready}, 2'b11);
        drive_byte(1'b0, 8'h11, 1'b0);
        drive_byte(1'b0, 8'h22, 1'b0);
        drive_byte(1'b0, 8'h33, 1'b0);
        chk("first_write", {a_wr_en, a_wr_addr, a_wr_data}, {1'b1, 5'd0, 24'h112233});
        drive_byte(1'b0, 8'h44, 1'b0);
        chk("wr_en_one_cycle", a_wr_en, 64'd0);
        for (int i = 4; i < 3 * A_NPIX; i++) begin
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            drive_byte(1'b0, 8'($urandom), 1'b0);
        end
        chk("last_state", {a_wr_en, a_frame_done, a_busy, a_in_ready, a_wr_addr}, {4'b1110, 5'd24});
        last_px = {frame_q[72], frame_q[73], frame_q[74]};
        tick(1);
        chk("idle_after_frame", {a_wr_en, a_frame_done, a_busy, a_in_ready}, 64'd0);
        tick(3);
        chk("hold_addr_data", {a_wr_addr, a_wr_data}, {5'd24, last_px});
        build_exp(1'b0, A_NPIX);
        compare_sb(1'b0);

        // Stall mid-pixel for 10 cycles.
        pulse_start(1'b0);
        drive_byte(1'b0, 8'hAA, 1'b0);
        drive_byte(1'b0, 8'hBB, 1'b0);
        tick(10);
        chk("no_write_during_stall", 64'(obs_qa.size()), 64'd0);
        drive_byte(1'b0, 8'h44, 1'b0);
        chk("write_after_stall", {a_wr_en, a_wr_addr, a_wr_data}, {1'b1, 5'd0, 24'hAABB44});
        pulse_abort(1'b0);
        chk("abort_to_idle", a_busy, 64'd0);
        build_exp(1'b0, A_NPIX);
        compare_sb(1'b0);

        // Start ignored mid-frame; abort coincident with B of pixel 5.
        pulse_start(1'b0);
        for (int p = 0; p < 5; p++) begin
            if (p == 3) pulse_start(1'b0);
            for (int k = 0; k < 3; k++) drive_byte(1'b0, 8'($urandom), 1'b0);
        end
        drive_byte(1'b0, 8'($urandom), 1'b0);
        drive_byte(1'b0, 8'($urandom), 1'b0);
        drive_byte(1'b0, 8'($urandom), 1'b1);
        chk("abort_on_b_byte", {a_wr_en, a_busy}, 64'd0);
        tick(2);
        build_exp(1'b0, A_NPIX);
        compare_sb(1'b0);
        pulse_start(1'b0);
        drive_byte(1'b0, 8'hC1, 1'b0);
        drive_byte(1'b0, 8'hC2, 1'b0);
        drive_byte(1'b0, 8'hC3, 1'b0);
        chk("restart_addr0", {a_wr_en, a_wr_addr, a_wr_data}, {1'b1, 5'd0, 24'hC1C2C3});
        pulse_abort(1'b0);
        build_exp(1'b0, A_NPIX);
        compare_sb(1'b0);

        // Start and abort together in IDLE.
        start_a = 1'b1;
        abort_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("start_abort_same_cycle", a_busy, 64'd0);

        // Reset mid-frame with the pixel address at 17.
        pulse_start(1'b0);
        for (int i = 0; i < 3 * 17 + 1; i++) begin
            if ($urandom_range(0, 4) == 0) tick(1);
            drive_byte(1'b0, 8'($urandom), 1'b0);
        end
        #2 reset = 1'b0;
        #1;
        chk("async_reset_midframe",
            {a_wr_en, a_frame_done, a_busy, a_in_ready, a_wr_addr, a_wr_data}, 64'd0);
        build_exp(1'b0, A_NPIX);
        tick(2);
        compare_sb(1'b0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        tick(2);
        chk("wait_for_start", a_busy, 64'd0);
        pulse_start(1'b0);
        drive_byte(1'b0, 8'h5A, 1'b0);
        drive_byte(1'b0, 8'h5B, 1'b0);
        drive_byte(1'b0, 8'h5C, 1'b0);
        chk("post_reset_addr0", {a_wr_en, a_wr_addr, a_wr_data}, {1'b1, 5'd0, 24'h5A5B5C});
        pulse_abort(1'b0);
        build_exp(1'b0, A_NPIX);
        compare_sb(1'b0);

        // Complete 2x2 frame, bytes 0x01..0x0C back-to-back.
        pulse_start(1'b1);
        for (int i = 1; i <= 12; i++) drive_byte(1'b1, 8'(i), 1'b0);
        chk("small_last", {b_wr_en, b_frame_done, b_busy, b_in_ready, b_wr_addr, b_wr_data},
            {4'b1110, 2'd3, 24'h0A0B0C});
        tick(1);
        chk("small_idle", {b_wr_en, b_frame_done, b_busy, b_in_ready}, 64'd0);
        chk("small_state", b_dbg_state, IDLE);
        build_exp(1'b1, B_NPIX);
        compare_sb(1'b1);
        compare_sb(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
